edge_buffer_wb_arbiter: RTL and testbench

Round-robin arbiter that shares the single output-SRAM write-back port among `NUM_BANKS` edge buffer banks. Each bank raises a write-back request after completing an aggregation pass; the arbiter issues a one-cycle grant to one bank at a time. It then forwards that bank's two-feature-per-beat stream (sos…eos) to the output SRAM request path with a one-cycle registered latency. It also detects protocol errors and stalled streams, so a faulty bank cannot hold the port indefinitely.

---
 rtl/edge_buffer_wb_arbiter.sv | 170 +++++++++++++++++
 tb/tb_edge_buffer_wb_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_buffer_wb_arbiter.sv
// Round-robin arbiter that shares the output-SRAM write-back port among edge buffer banks.
// It forwards the granted bank's sos..eos stream with one cycle of latency and aborts faulty or stalled banks.
module edge_buffer_wb_arbiter #(
    parameter int NUM_BANKS = 4,
    parameter int DATA_W    = 16,
    parameter int NODE_W    = 8,
    parameter int TIMEOUT   = 15
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_BANKS-1:0]          bank_req,
    input  logic [NUM_BANKS-1:0]          bank_valid,
    input  logic [NUM_BANKS-1:0]          bank_sos,
    input  logic [NUM_BANKS-1:0]          bank_eos,
    input  logic [NUM_BANKS*2*DATA_W-1:0] bank_data,
    input  logic [NUM_BANKS*NODE_W-1:0]   bank_nodeid,
    input  logic                          sram_ready,
    output logic [NUM_BANKS-1:0]          bank_grant,
    output logic                          sram_valid,
    output logic                          sram_sos,
    output logic                          sram_eos,
    output logic [2*DATA_W-1:0]           sram_data,
    output logic [NODE_W-1:0]             sram_nodeid,
    output logic [$clog2(NUM_BANKS)-1:0]  sram_owner,
    output logic [7:0]                    last_len,
    output logic                          proto_err,
    output logic                          timeout_err
);

    localparam int IDX_W  = $clog2(NUM_BANKS);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, GRANT, STREAM} state_t;

    state_t              state, state_d;
    logic [IDX_W-1:0]    rr_ptr, rr_ptr_d, owner, owner_d, winner, next_ptr;
    logic [7:0]          beat_cnt, beat_cnt_d, beat_inc, last_len_d;
    logic [IDLE_W-1:0]   idle_cnt, idle_cnt_d;
    logic [NUM_BANKS-1:0] grant_d, own_mask;
    logic                found, fwd, force_eos, proto_d, timeout_d;
    logic                own_valid, own_sos, own_eos;
    logic [2*DATA_W-1:0] own_data;
    logic [NODE_W-1:0]   own_nodeid;

    assign own_valid  = bank_valid[owner];
    assign own_sos    = bank_sos[owner];
    assign own_eos    = bank_eos[owner];
    assign own_data   = bank_data[int'(owner)*2*DATA_W +: 2*DATA_W];
    assign own_nodeid = bank_nodeid[int'(owner)*NODE_W +: NODE_W];
    assign own_mask   = (state == IDLE) ? '0 : (NUM_BANKS'(1) << owner);
    assign next_ptr   = (owner == IDX_W'(NUM_BANKS - 1)) ? '0 : owner + IDX_W'(1);
    assign beat_inc   = (beat_cnt == 8'hFF) ? 8'hFF : beat_cnt + 8'd1;
    assign sram_owner = owner;

    // First requester at or after rr_ptr, searching upward with wrap.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (!found && bank_req[(int'(rr_ptr) + i) % NUM_BANKS]) begin
                winner = IDX_W'((int'(rr_ptr) + i) % NUM_BANKS);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
        state_d    = state;
        rr_ptr_d   = rr_ptr;
        owner_d    = owner;
        beat_cnt_d = beat_cnt;
        idle_cnt_d = idle_cnt;
        last_len_d = last_len;
        grant_d    = '0;
        fwd        = 1'b0;
        force_eos  = 1'b0;
        timeout_d  = 1'b0;
        proto_d    = |(bank_valid & ~own_mask);

        unique case (state)
            IDLE: begin
                idle_cnt_d = '0;
                if (found && sram_ready) begin
                    grant_d    = NUM_BANKS'(1) << winner;
                    owner_d    = winner;
                    beat_cnt_d = '0;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                if (own_valid && own_sos) begin
                    fwd = 1'b1;
                    if (own_eos) begin
                        last_len_d = 8'd1;
                        rr_ptr_d   = next_ptr;
                        state_d    = IDLE;
                    end else begin
                        beat_cnt_d = 8'd1;
                        idle_cnt_d = '0;
                        state_d    = STREAM;
                    end
                end else begin
                    proto_d  = 1'b1;
                    rr_ptr_d = next_ptr;
                    state_d  = IDLE;
                end
            end
            STREAM: begin
                if (own_valid) begin
                    fwd        = 1'b1;
                    beat_cnt_d = beat_inc;
                    idle_cnt_d = '0;
                    if (own_sos) proto_d = 1'b1;
                    if (own_eos) begin
                        last_len_d = beat_inc;
                        rr_ptr_d   = next_ptr;
                        state_d    = IDLE;
                    end
                end else if (idle_cnt == IDLE_W'(TIMEOUT - 1)) begin
                    // Stalled owner: close the stream with a data-less eos and free the port.
                    timeout_d  = 1'b1;
                    force_eos  = 1'b1;
                    idle_cnt_d = '0;
                    rr_ptr_d   = next_ptr;
                    state_d    = IDLE;
                end else begin
                    idle_cnt_d = idle_cnt + IDLE_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            owner       <= '0;
            beat_cnt    <= '0;
            idle_cnt    <= '0;
            bank_grant  <= '0;
            sram_valid  <= 1'b0;
            sram_sos    <= 1'b0;
            sram_eos    <= 1'b0;
            sram_data   <= '0;
            sram_nodeid <= '0;
            last_len    <= '0;
            proto_err   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_d;
            rr_ptr      <= rr_ptr_d;
            owner       <= owner_d;
            beat_cnt    <= beat_cnt_d;
            idle_cnt    <= idle_cnt_d;
            bank_grant  <= grant_d;
            sram_valid  <= fwd;
            sram_sos    <= fwd & own_sos;
            sram_eos    <= (fwd & own_eos) | force_eos;
            sram_data   <= fwd ? own_data : '0;
            sram_nodeid <= fwd ? own_nodeid : '0;
            last_len    <= last_len_d;
            proto_err   <= proto_d;
            timeout_err <= timeout_d;
        end
    end

endmodule

// File: tb/tb_edge_buffer_wb_arbiter.sv
// Directed bench for edge_buffer_wb_arbiter: grant order, stream forwarding, error pulses and reset.
module tb_edge_buffer_wb_arbiter;

    localparam int NB = 4;
    localparam int DW = 16;
    localparam int NW = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [NB-1:0]     bank_req, bank_valid, bank_sos, bank_eos;
    logic [NB*2*DW-1:0] bank_data;
    logic [NB*NW-1:0]  bank_nodeid;
    logic              sram_ready;
    logic [NB-1:0]     bank_grant;
    logic              sram_valid, sram_sos, sram_eos;
    logic [2*DW-1:0]   sram_data;
    logic [NW-1:0]     sram_nodeid;
    logic [1:0]        sram_owner;
    logic [7:0]        last_len;
    logic              proto_err, timeout_err;

    int checks   = 0;
    int failures = 0;

    edge_buffer_wb_arbiter #(.NUM_BANKS(NB), .DATA_W(DW), .NODE_W(NW), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset),
        .bank_req(bank_req), .bank_valid(bank_valid), .bank_sos(bank_sos), .bank_eos(bank_eos),
        .bank_data(bank_data), .bank_nodeid(bank_nodeid), .sram_ready(sram_ready),
        .bank_grant(bank_grant), .sram_valid(sram_valid), .sram_sos(sram_sos), .sram_eos(sram_eos),
        .sram_data(sram_data), .sram_nodeid(sram_nodeid), .sram_owner(sram_owner),
        .last_len(last_len), .proto_err(proto_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_banks();
        bank_valid  = '0;
        bank_sos    = '0;
        bank_eos    = '0;
        bank_data   = '0;
        bank_nodeid = '0;
    endtask

    task automatic beat(input int b, input logic sos, input logic eos,
                        input logic [31:0] d, input logic [7:0] n);
        idle_banks();
        bank_valid[b]         = 1'b1;
        bank_sos[b]           = sos;
        bank_eos[b]           = eos;
        bank_data[b*32 +: 32] = d;
        bank_nodeid[b*8 +: 8] = n;
    endtask

    task automatic check_beat(input string tag, input logic sos, input logic eos,
                              input logic [31:0] d, input logic [7:0] n);
        check({tag, "_valid"}, 64'(sram_valid), 64'd1);
        check({tag, "_sos"}, 64'(sram_sos), 64'(sos));
        check({tag, "_eos"}, 64'(sram_eos), 64'(eos));
        check({tag, "_data"}, 64'(sram_data), 64'(d));
        check({tag, "_nodeid"}, 64'(sram_nodeid), 64'(n));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"}, 64'(bank_grant), 64'd0);
        check({tag, "_valid"}, 64'(sram_valid), 64'd0);
        check({tag, "_sos"}, 64'(sram_sos), 64'd0);
        check({tag, "_eos"}, 64'(sram_eos), 64'd0);
        check({tag, "_data"}, 64'(sram_data), 64'd0);
        check({tag, "_nodeid"}, 64'(sram_nodeid), 64'd0);
        check({tag, "_owner"}, 64'(sram_owner), 64'd0);
        check({tag, "_last_len"}, 64'(last_len), 64'd0);
        check({tag, "_proto"}, 64'(proto_err), 64'd0);
        check({tag, "_timeout"}, 64'(timeout_err), 64'd0);
    endtask

    initial begin
        reset      = 1'b0;
        sram_ready = 1'b0;
        bank_req   = '0;
        idle_banks();
        repeat (3) tick();
        check_all_zero("rst");
        reset = 1'b1;
        tick();
        check_all_zero("rst_rel");

        // Non-owner valid while idle: flagged, never forwarded.
        beat(1, 1'b1, 1'b0, 32'hDEAD_BEEF, 8'h11);
        tick();
        check("foreign_proto", 64'(proto_err), 64'd1);
        check("foreign_fwd", 64'(sram_valid), 64'd0);
        idle_banks();
        tick();
        check("foreign_proto_clr", 64'(proto_err), 64'd0);

        // Single 4-beat transfer from bank2.
        sram_ready = 1'b1;
        bank_req   = 4'b0100;
        tick();
        check("t1_grant", 64'(bank_grant), 64'b0100);
        check("t1_owner", 64'(sram_owner), 64'd2);
        check("t1_pre_valid", 64'(sram_valid), 64'd0);
        bank_req = '0;
        for (int k = 1; k <= 4; k++) begin
            beat(2, k == 1, k == 4, 32'h2000_0000 + 32'(k), 8'h20 + 8'(k));
            tick();
            check_beat($sformatf("t1_beat%0d", k), k == 1, k == 4, 32'h2000_0000 + 32'(k), 8'h20 + 8'(k));
            check($sformatf("t1_grant_off%0d", k), 64'(bank_grant), 64'd0);
        end
        check("t1_last_len", 64'(last_len), 64'd4);
        check("t1_rr_ptr", 64'(dut.rr_ptr), 64'd3);
        idle_banks();
        tick();
        check("t1_after_valid", 64'(sram_valid), 64'd0);

        // Bank3 granted but sends no sos.
        bank_req = 4'b1000;
        tick();
        check("nosos_grant", 64'(bank_grant), 64'b1000);
        bank_req = '0;
        tick();
        check("nosos_proto", 64'(proto_err), 64'd1);
        check("nosos_valid", 64'(sram_valid), 64'd0);
        check("nosos_grant_off", 64'(bank_grant), 64'd0);
        tick();
        check("nosos_proto_pulse", 64'(proto_err), 64'd0);
        check("nosos_rr_ptr", 64'(dut.rr_ptr), 64'd0);
        check("nosos_no_grant", 64'(bank_grant), 64'd0);

        // Fairness: all banks request, 2-beat streams, order 0,1,2,3,0.
        bank_req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            int b;
            b = t % 4;
            tick();
            check($sformatf("rr_grant%0d", t), 64'(bank_grant), 64'(4'b0001 << b));
            check($sformatf("rr_owner%0d", t), 64'(sram_owner), 64'(b));
            beat(b, 1'b1, 1'b0, 32'hA000_0000 + 32'(t), 8'(b));
            tick();
            check_beat($sformatf("rr_b1_%0d", t), 1'b1, 1'b0, 32'hA000_0000 + 32'(t), 8'(b));
            beat(b, 1'b0, 1'b1, 32'hB000_0000 + 32'(t), 8'(b));
            tick();
            check_beat($sformatf("rr_b2_%0d", t), 1'b0, 1'b1, 32'hB000_0000 + 32'(t), 8'(b));
            check($sformatf("rr_len%0d", t), 64'(last_len), 64'd2);
            check($sformatf("rr_gap%0d", t), 64'(bank_grant), 64'd0);
            check($sformatf("rr_proto%0d", t), 64'(proto_err), 64'd0);
            idle_banks();
        end
        bank_req = '0;
        tick();

        // sram_ready low holds off the grant.
        sram_ready = 1'b0;
        bank_req   = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("nordy_grant%0d", i), 64'(bank_grant), 64'd0);
        end
        sram_ready = 1'b1;
        tick();
        check("rdy_grant", 64'(bank_grant), 64'b0010);
        bank_req = '0;
        beat(1, 1'b1, 1'b1, 32'h1111_2222, 8'h31);
        tick();
        check_beat("rdy_beat", 1'b1, 1'b1, 32'h1111_2222, 8'h31);
        check("rdy_len", 64'(last_len), 64'd1);
        idle_banks();
        tick();

        // Stall: bank0 sends 2 beats then goes quiet; bank1 waits.
        bank_req = 4'b0001;
        tick();
        check("stall_grant", 64'(bank_grant), 64'b0001);
        bank_req = '0;
        beat(0, 1'b1, 1'b0, 32'h0000_00A1, 8'h01);
        tick();
        check_beat("stall_b1", 1'b1, 1'b0, 32'h0000_00A1, 8'h01);
        beat(0, 1'b0, 1'b0, 32'h0000_00A2, 8'h02);
        tick();
        check_beat("stall_b2", 1'b0, 1'b0, 32'h0000_00A2, 8'h02);
        idle_banks();
        bank_req = 4'b0010;
        for (int i = 1; i <= 14; i++) tick();
        check("stall_no_to_yet", 64'(timeout_err), 64'd0);
        check("stall_no_eos_yet", 64'(sram_eos), 64'd0);
        tick();
        check("stall_timeout", 64'(timeout_err), 64'd1);
        check("stall_forced_eos", 64'(sram_eos), 64'd1);
        check("stall_valid", 64'(sram_valid), 64'd0);
        check("stall_rr_ptr", 64'(dut.rr_ptr), 64'd1);
        tick();
        check("stall_next_grant", 64'(bank_grant), 64'b0010);
        check("stall_timeout_pulse", 64'(timeout_err), 64'd0);
        bank_req = '0;
        beat(1, 1'b1, 1'b1, 32'h5555_6666, 8'h41);
        tick();
        check_beat("stall_next_beat", 1'b1, 1'b1, 32'h5555_6666, 8'h41);
        idle_banks();
        tick();

        // Reset in the middle of a bank3 stream.
        bank_req = 4'b1000;
        tick();
        check("mid_grant", 64'(bank_grant), 64'b1000);
        bank_req = '0;
        beat(3, 1'b1, 1'b0, 32'h3300_0001, 8'h33);
        tick();
        beat(3, 1'b0, 1'b0, 32'h3300_0002, 8'h34);
        tick();
        check("mid_valid", 64'(sram_valid), 64'd1);
        check("mid_owner", 64'(sram_owner), 64'd3);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("mid_rst");
        idle_banks();
        tick();
        reset    = 1'b1;
        bank_req = 4'b1010;
        tick();
        check("post_rst_grant", 64'(bank_grant), 64'b0010);
        check("post_rst_owner", 64'(sram_owner), 64'd1);
        bank_req = '0;
        beat(1, 1'b1, 1'b1, 32'h7777_8888, 8'h51);
        tick();
        check_beat("post_rst_beat", 1'b1, 1'b1, 32'h7777_8888, 8'h51);
        idle_banks();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
